// File: rtl/bram_stream_reader_if.sv
// Request, memory read port and output stream signals of bram_stream_reader.
// master is the reader; slave is the memory/consumer side.
interface bram_stream_reader_if #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = ADDR_W + 1
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  length;
    logic [ADDR_W-1:0] read_addr;
    logic              read_val;
    logic              out_val;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;

    modport master (
        input  start, base_addr, length, read_val, out_ready,
        output read_addr, out_val, out_valid, busy, done
    );

    modport slave (
        output start, base_addr, length, read_val, out_ready,
        input  read_addr, out_val, out_valid, busy, done
    );
endinterface

// File: rtl/bram_stream_reader.sv
// Streams a run of bits out of a 1-cycle-latency memory into a ready/valid
// sink through a 2-entry register FIFO, wrapping addresses modulo 2**ADDR_W.
//
//   state  | meaning
//   IDLE   | waiting for start
//   RUN    | issuing reads and delivering beats
//   FINISH | one-cycle done pulse, then back to IDLE
module bram_stream_reader #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = ADDR_W + 1
) (
    input logic                  clk,
    input logic                  rst,
    bram_stream_reader_if.master bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0] rd_addr;
    logic [LEN_W-1:0]  reads_left;
    logic [LEN_W-1:0]  beats_left;
    logic              armed;
    logic              rv_pend;
    logic              v0, v1;
    logic              d0, d1;
    logic              pop;
    logic              issue;
    logic              last_beat;
    logic [1:0]        credit;
    logic              busy_c;
    logic              done_c;

    assign pop       = v0 & bus.out_ready;
    assign last_beat = pop && (beats_left == LEN_W'(1));

    // Slots the FIFO will hold once the read returning now lands and this cycle's pop leaves.
    assign credit = {1'b0, v0} + {1'b0, v1} + {1'b0, rv_pend} - {1'b0, pop};
    assign issue  = (state == RUN) && armed && (reads_left != '0) && (credit < 2'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy_c     = 1'b0;
        done_c     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = (bus.length == '0) ? FINISH : RUN;
                end
            end
            RUN: begin
                busy_c = 1'b1;
                if (last_beat) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                busy_c     = 1'b1;
                done_c     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr    <= '0;
            reads_left <= '0;
            beats_left <= '0;
            armed      <= 1'b0;
            rv_pend    <= 1'b0;
        end else begin
            // First RUN cycle only settles read_addr; reads start the cycle after.
            armed   <= (state == RUN);
            rv_pend <= issue;
            if (state == IDLE && bus.start && bus.length != '0) begin
                rd_addr    <= bus.base_addr;
                reads_left <= bus.length;
                beats_left <= bus.length;
            end
            if (issue) begin
                reads_left <= reads_left - LEN_W'(1);
                if (reads_left != LEN_W'(1)) begin
                    rd_addr <= rd_addr + ADDR_W'(1);
                end
            end
            if (pop) begin
                beats_left <= beats_left - LEN_W'(1);
            end
        end
    end

    // d0 is always the head so out_val comes straight from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            v0 <= 1'b0;
            v1 <= 1'b0;
            d0 <= 1'b0;
            d1 <= 1'b0;
        end else begin
            case ({rv_pend, pop})
                2'b10: begin
                    if (!v0) begin
                        v0 <= 1'b1;
                        d0 <= bus.read_val;
                    end else begin
                        v1 <= 1'b1;
                        d1 <= bus.read_val;
                    end
                end
                2'b01: begin
                    d0 <= d1;
                    v0 <= v1;
                    v1 <= 1'b0;
                end
                2'b11: begin
                    if (v1) begin
                        d0 <= d1;
                        d1 <= bus.read_val;
                    end else begin
                        d0 <= bus.read_val;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.read_addr = rd_addr;
    assign bus.out_val   = d0;
    assign bus.out_valid = v0;
    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
endmodule
